// File: rtl/pe_act_broadcast_engine.sv
// PE activation broadcast engine: scans the activation flags for eligible entries,
// reads each through a 1-cycle read port into a 2-entry skid FIFO, and streams them to the router.
module pe_act_broadcast_engine #(
  parameter int                         ACT_NO        = 16,
  parameter int                         DATA_W        = 16,
  parameter int                         PE_IDX_W      = 6,
  parameter int                         ROUTER_ADDR_W = 4,
  parameter logic [ROUTER_ADDR_W-1:0]   BCAST_ADDR    = '0,
  localparam int                        AW            = $clog2(ACT_NO)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PE_IDX_W-1:0]       PE_IDX,
  input  logic                      start,
  input  logic                      abort,
  input  logic [AW:0]               in_act_no,
  input  logic                      relu_en,
  input  logic [ACT_NO-1:0]         in_act_zeros,
  input  logic [ACT_NO-1:0]         in_act_g_zeros,
  output logic                      in_act_read_en,
  output logic [AW-1:0]             in_act_read_addr,
  input  logic [DATA_W-1:0]         in_act_read_data,
  input  logic                      router_rdy,
  output logic                      act_send_en,
  output logic [ROUTER_ADDR_W-1:0]  act_send_addr,
  output logic [DATA_W-1:0]         act_send_data,
  output logic [PE_IDX_W+AW-1:0]    act_send_idx,
  output logic                      busy,
  output logic                      done,
  output logic [AW:0]               sent_cnt
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_e;

  typedef struct packed {
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_e            state_q, state_d;
  logic [ACT_NO-1:0] pending_q, pending_d;
  logic              inflight_q, inflight_d;
  logic [AW-1:0]     inflight_addr_q, inflight_addr_d;
  entry_t            fifo_mem_q [2];
  entry_t            fifo_mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic [AW:0]       sent_cnt_q, sent_cnt_d;

  logic [ACT_NO-1:0] range_mask;
  logic [ACT_NO-1:0] eligible;
  logic [AW-1:0]     low_addr;
  logic              abort_act, push, pop, issue;
  entry_t            head;

  // Eligibility snapshot and single-cycle lowest-set-bit pick over pending entries.
  always_comb begin
    for (int i = 0; i < ACT_NO; i++) range_mask[i] = (AW+1)'(i) < in_act_no;
    eligible = (relu_en ? in_act_g_zeros : ~in_act_zeros) & range_mask;
    low_addr = '0;
    for (int i = ACT_NO-1; i >= 0; i--) if (pending_q[i]) low_addr = AW'(i);
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    abort_act = abort && (state_q != IDLE);
    head      = fifo_mem_q[rd_ptr_q];
    pop       = (count_q != 2'd0) && router_rdy && !abort_act;
    push      = inflight_q && !abort_act;
    // A pop this cycle frees a slot, which lets reads and sends overlap at full rate.
    issue     = (state_q == SCAN) && (pending_q != '0) &&
                (({1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop}) < 3'd2);

    in_act_read_en   = issue;
    in_act_read_addr = issue ? low_addr : '0;
    act_send_en      = pop;
    act_send_addr    = pop ? BCAST_ADDR : '0;
    act_send_data    = pop ? head.data : '0;
    act_send_idx     = pop ? {PE_IDX, head.addr} : '0;
    busy             = (state_q != IDLE);
    done             = (state_q == DONE);
    sent_cnt         = sent_cnt_q;

    state_d         = state_q;
    pending_d       = pending_q;
    inflight_d      = 1'b0;
    inflight_addr_d = inflight_addr_q;
    fifo_mem_d      = fifo_mem_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    sent_cnt_d      = sent_cnt_q;
    count_d         = count_q + 2'(push) - 2'(pop);

    if (push) begin
      fifo_mem_d[wr_ptr_q] = {inflight_addr_q, in_act_read_data};
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d   = ~rd_ptr_q;
      sent_cnt_d = sent_cnt_q + (AW+1)'(1);
    end
    if (issue) begin
      pending_d[low_addr] = 1'b0;
      inflight_d          = 1'b1;
      inflight_addr_d     = low_addr;
    end

    unique case (state_q)
      IDLE: if (start && !abort) begin
        state_d    = SCAN;
        pending_d  = eligible;
        sent_cnt_d = '0;
      end
      SCAN:    if (pending_d == '0) state_d = DRAIN;
      DRAIN:   if (!inflight_q && (count_q == 2'd0)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort_act) begin
      state_d    = IDLE;
      pending_d  = '0;
      inflight_d = 1'b0;
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
      count_d    = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
    if (!rst) begin
      state_q         <= IDLE;
      pending_q       <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
      sent_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      pending_q       <= pending_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      sent_cnt_q      <= sent_cnt_d;
    end
  end

  // NOTE: FIFO storage is not reset; count/pointers qualify it and send outputs are gated by pop.
  always_ff @(posedge clk) fifo_mem_q <= fifo_mem_d;

endmodule

// File: tb/tb_pe_act_broadcast_engine.sv
// Self-checking bench for pe_act_broadcast_engine: directed scenarios plus randomized runs
// compared against a list-based reference of which entries must be broadcast, in order.
module tb_pe_act_broadcast_engine;

  localparam int ACT_NO        = 16;
  localparam int DATA_W        = 16;
  localparam int PE_IDX_W      = 6;
  localparam int ROUTER_ADDR_W = 4;
  localparam int AW            = 4;
  localparam int IDX_W         = PE_IDX_W + AW;
  localparam logic [ROUTER_ADDR_W-1:0] BCAST_ADDR = 4'hA;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [PE_IDX_W-1:0]      pe_idx;
  logic                     start, abort, relu_en, router_rdy;
  logic [AW:0]              in_act_no;
  logic [ACT_NO-1:0]        in_act_zeros, in_act_g_zeros;
  logic                     in_act_read_en;
  logic [AW-1:0]            in_act_read_addr;
  logic [DATA_W-1:0]        in_act_read_data;
  logic                     act_send_en;
  logic [ROUTER_ADDR_W-1:0] act_send_addr;
  logic [DATA_W-1:0]        act_send_data;
  logic [IDX_W-1:0]         act_send_idx;
  logic                     busy, done;
  logic [AW:0]              sent_cnt;

  pe_act_broadcast_engine #(
    .ACT_NO(ACT_NO), .DATA_W(DATA_W), .PE_IDX_W(PE_IDX_W),
    .ROUTER_ADDR_W(ROUTER_ADDR_W), .BCAST_ADDR(BCAST_ADDR)
  ) dut (
    .clk(clk), .rst(rst), .PE_IDX(pe_idx), .start(start), .abort(abort),
    .in_act_no(in_act_no), .relu_en(relu_en), .in_act_zeros(in_act_zeros),
    .in_act_g_zeros(in_act_g_zeros), .in_act_read_en(in_act_read_en),
    .in_act_read_addr(in_act_read_addr), .in_act_read_data(in_act_read_data),
    .router_rdy(router_rdy), .act_send_en(act_send_en), .act_send_addr(act_send_addr),
    .act_send_data(act_send_data), .act_send_idx(act_send_idx), .busy(busy),
    .done(done), .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Activation register file with a 1-cycle read latency; garbage when not read.
  logic [DATA_W-1:0] regfile [ACT_NO];
  always @(posedge clk)
    in_act_read_data <= in_act_read_en ? regfile[in_act_read_addr] : DATA_W'($urandom);

  // Monitor: samples on the falling edge, away from the active edge.
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  logic [IDX_W+DATA_W-1:0] obs_q[$];
  int send_cyc_q[$];
  int n_reads, n_sends, done_cnt, done_cyc, max_out;

  always @(negedge clk) begin
    if (rst) begin
      if (in_act_read_en) n_reads++;
      if (act_send_en) begin
        obs_q.push_back({act_send_idx, act_send_data});
        send_cyc_q.push_back(cyc_cnt);
        n_sends++;
        check("send_addr", 64'(act_send_addr), 64'(BCAST_ADDR));
      end
      if (n_reads - n_sends > max_out) max_out = n_reads - n_sends;
      if (done) begin
        done_cnt++;
        done_cyc = cyc_cnt;
      end
    end
  end

  // zero entries -> 0, positive entries -> (0, 0x7fff], the rest negative
  task automatic load_regfile(input logic [ACT_NO-1:0] zmask, input logic [ACT_NO-1:0] pmask);
    for (int i = 0; i < ACT_NO; i++) begin
      if (zmask[i])      regfile[i] = '0;
      else if (pmask[i]) regfile[i] = DATA_W'($urandom_range(1, 32'h7fff));
      else               regfile[i] = DATA_W'($urandom_range(32'h8000, 32'hffff));
    end
  endtask

  task automatic run(input string tag, input int n, input bit relu, input int rdy_mode,
                     input int abort_after, input bit stray_start);
    logic [IDX_W+DATA_W-1:0] exp_q[$];
    int  start_cyc, n_chk;
    bit  aborted, finished;
    for (int i = 0; i < n; i++) begin
      if (relu ? ($signed(regfile[i]) > 0) : (regfile[i] != '0))
        exp_q.push_back({pe_idx, AW'(i), regfile[i]});
    end
    obs_q.delete();
    send_cyc_q.delete();
    n_reads = 0; n_sends = 0; done_cnt = 0; max_out = 0; done_cyc = 0;
    for (int i = 0; i < ACT_NO; i++) begin
      in_act_zeros[i]   = (regfile[i] == '0);
      in_act_g_zeros[i] = ($signed(regfile[i]) > 0);
    end
    in_act_no = (AW+1)'(n);
    relu_en   = relu;
    start     = 1'b1;
    @(posedge clk); #1;
    start_cyc = cyc_cnt;
    start          = 1'b0;
    relu_en        = ~relu;
    in_act_no      = (AW+1)'($urandom_range(0, ACT_NO));
    in_act_zeros   = ACT_NO'($urandom);
    in_act_g_zeros = ACT_NO'($urandom);

    aborted = 1'b0;
    finished = 1'b0;
    for (int c = 0; c < 400 && !finished; c++) begin
      case (rdy_mode)
        0:       router_rdy = 1'b1;
        1:       router_rdy = (c % 3 == 0);
        default: router_rdy = 1'($urandom_range(0, 1));
      endcase
      start = stray_start && (c == 1);
      abort = (abort_after > 0) && (obs_q.size() == abort_after);
      @(posedge clk); #1;
      if (abort) begin
        aborted  = 1'b1;
        abort    = 1'b0;
        finished = 1'b1;
      end
      if (done_cnt > 0) finished = 1'b1;
    end
    start = 1'b0;
    router_rdy = 1'b1;
    check($sformatf("%s finished", tag), 64'(finished), 64'd1);
    repeat (3) @(posedge clk);
    #1;

    if (aborted) begin
      n_chk = abort_after;
      check($sformatf("%s abort_flits", tag), 64'(obs_q.size()), 64'(abort_after));
      check($sformatf("%s abort_no_done", tag), 64'(done_cnt), 64'd0);
    end else begin
      n_chk = exp_q.size();
      check($sformatf("%s flit_count", tag), 64'(obs_q.size()), 64'(exp_q.size()));
      check($sformatf("%s read_count", tag), 64'(n_reads), 64'(exp_q.size()));
      check($sformatf("%s done_pulses", tag), 64'(done_cnt), 64'd1);
      if (exp_q.size() == 0)
        check($sformatf("%s done_latency", tag), 64'(done_cyc - start_cyc), 64'd2);
      if (rdy_mode == 0 && obs_q.size() > 1)
        check($sformatf("%s back_to_back", tag),
              64'(send_cyc_q[send_cyc_q.size()-1] - send_cyc_q[0]), 64'(obs_q.size() - 1));
    end
    for (int i = 0; i < n_chk && i < obs_q.size(); i++)
      check($sformatf("%s flit%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
    check($sformatf("%s sent_cnt", tag), 64'(sent_cnt), 64'(n_chk));
    check($sformatf("%s idle_after", tag), 64'(busy), 64'd0);
    check($sformatf("%s outstanding_le2", tag), 64'(max_out <= 2), 64'd1);
  endtask

  initial begin
    rst = 1'b0;
    pe_idx = 6'h2B;
    router_rdy = 1'b1;
    for (int i = 0; i < ACT_NO; i++) regfile[i] = '0;
    repeat (2) begin
      start          = 1'($urandom_range(0, 1));
      abort          = 1'($urandom_range(0, 1));
      relu_en        = 1'($urandom_range(0, 1));
      router_rdy     = 1'($urandom_range(0, 1));
      in_act_no      = (AW+1)'($urandom_range(0, ACT_NO));
      in_act_zeros   = ACT_NO'($urandom);
      in_act_g_zeros = ACT_NO'($urandom);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("rst read_en",   64'(in_act_read_en), 64'd0);
    check("rst send_en",   64'(act_send_en),    64'd0);
    check("rst send_addr", 64'(act_send_addr),  64'd0);
    check("rst send_data", 64'(act_send_data),  64'd0);
    check("rst send_idx",  64'(act_send_idx),   64'd0);
    check("rst busy",      64'(busy),           64'd0);
    check("rst done",      64'(done),           64'd0);
    check("rst sent_cnt",  64'(sent_cnt),       64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    router_rdy = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;

    // zeros = 0x00A5 over the first 8 entries -> indices 1, 3, 4, 6
    load_regfile(16'h00A5, 16'h0000);
    run("basic", 8, 1'b0, 0, 0, 1'b0);

    // only entries 0 and 4 strictly positive
    load_regfile(16'h0102, 16'h0011);
    run("relu", 16, 1'b1, 0, 0, 1'b0);

    // six non-zero entries {0,2,3,5,8,9}, router_rdy 1,0,0,..., stray start mid-run
    load_regfile(~16'h032D, 16'h0000);
    run("backpressure", 16, 1'b0, 1, 0, 1'b1);

    run("empty", 0, 1'b0, 0, 0, 1'b0);

    load_regfile(16'h0000, 16'hFFFF);
    run("abort", 16, 1'b0, 0, 2, 1'b0);

    load_regfile(16'h0000, ACT_NO'($urandom));
    run("after_abort", 10, 1'b1, 0, 0, 1'b0);

    // start and abort together in IDLE: abort wins
    in_act_no = (AW+1)'(ACT_NO);
    relu_en = 1'b0;
    in_act_zeros = '0;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check("idle_abort busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("idle_abort read_en", 64'(in_act_read_en), 64'd0);
    @(posedge clk); #1;

    for (int r = 0; r < 10; r++) begin
      logic [ACT_NO-1:0] zm, pm;
      zm = ACT_NO'($urandom);
      pm = ACT_NO'($urandom) & ~zm;
      load_regfile(zm, pm);
      run($sformatf("rand%0d", r), $urandom_range(0, ACT_NO), 1'($urandom_range(0, 1)),
          2, 0, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
